masked_pattern_detector: RTL and testbench



---
 rtl/masked_pattern_detector_pkg.sv | 26 ++
 rtl/masked_pattern_detector_slot_cmp.sv | 57 +++++
 rtl/masked_pattern_detector.sv | 222 ++++++++++++++++++++++
 tb/tb_masked_pattern_detector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// masked_pattern_pkg
//   Shared types and helpers for the masked pattern detector.
//   - mode_e    : detection mode (ANY = any enabled slot, SEQ = ordered slots)
//   - idx_width : width of a slot index for a given slot count
//   - sat_value : all-ones value of a counter of the given width (saturation
//                 point of the hit counter)
// -----------------------------------------------------------------------------
package masked_pattern_pkg;

  typedef enum logic {
    MODE_ANY = 1'b0,
    MODE_SEQ = 1'b1
  } mode_e;

  // Slot index width; a single slot still needs one bit of index.
  function automatic int idx_width(input int npat);
    return (npat > 1) ? $clog2(npat) : 1;
  endfunction

  // Largest value representable in cnt_w bits (capped at 32 bits).
  function automatic logic [31:0] sat_value(input int cnt_w);
    return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/masked_pattern_detector_slot_cmp.sv
// -----------------------------------------------------------------------------
// mpd_slot_cmp
//   One pattern slot of the masked pattern detector: stores pattern, mask and
//   enable, and flags whether the current data word matches.
//   A slot matches when it is enabled and every care bit (mask=1) of the data
//   equals the pattern. The match is computed from the stored configuration,
//   so a write in the same cycle only takes effect for later words.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset (clears the slot)
//   we_i        : write pattern/mask/enable at the clock edge
//   pattern_i   : expected bit values
//   mask_i      : 1 = care bit, 0 = don't care
//   en_i        : slot enable
//   data_i      : word under test
//   match_o     : slot matches data_i (combinational from stored config)
// -----------------------------------------------------------------------------
module mpd_slot_cmp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             match_o
);

  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] mask_q;
  logic             en_q;

  // Slot configuration storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      mask_q    <= '0;
      en_q      <= 1'b0;
    end else if (we_i) begin
      pattern_q <= pattern_i;
      mask_q    <= mask_i;
      en_q      <= en_i;
    end else begin
      pattern_q <= pattern_q;
      mask_q    <= mask_q;
      en_q      <= en_q;
    end
  end

  // Masked equality: differences in don't-care bits are ignored.
  always_comb begin
    match_o = en_q && (((data_i ^ pattern_q) & mask_q) == '0);
  end

endmodule

// File: rtl/masked_pattern_detector.sv
// -----------------------------------------------------------------------------
// masked_pattern_detector
//   Compares each valid input word against NPAT programmable pattern/mask
//   slots and raises a registered one-cycle hit pulse with the slot index.
//   ANY mode : hit when any enabled slot matches; lowest index wins.
//   SEQ mode : slots 0..seq_last must match in order on consecutive valid
//              beats (idle cycles between beats allowed); hit on the last.
//   A saturating hit counter counts pulses and can be cleared synchronously.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_data     : word under test and its qualifier
//   mode                  : 0 = ANY, 1 = SEQ
//   seq_last              : index of the final slot in SEQ mode
//   cfg_we, cfg_idx       : write slot cfg_idx (indices >= NPAT ignored)
//   cfg_pattern, cfg_mask : slot pattern and care mask
//   cfg_en                : slot enable
//   cnt_clr               : synchronous clear of hit_count
//   hit, hit_idx          : match pulse and producing slot (idx holds)
//   hit_count             : saturating hit count, updated with hit
//   seq_step              : current SEQ step
//   hit_sticky            : (only with MPD_STICKY_EN) set by hit, cleared by
//                           cnt_clr unless a hit occurs in the same cycle
//
// Build option: define MPD_STICKY_EN to add the hit_sticky output.
// -----------------------------------------------------------------------------
module masked_pattern_detector
  import masked_pattern_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NPAT  = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = idx_width(NPAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic [IDX_W-1:0] seq_last,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_en,
  input  logic             cnt_clr,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [CNT_W-1:0] hit_count,
  output logic [IDX_W-1:0] seq_step
`ifdef MPD_STICKY_EN
  ,
  output logic             hit_sticky
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));

  logic [NPAT-1:0]  match_s;
  logic             any_match_s;
  logic [IDX_W-1:0] low_idx_s;
  logic             step_match_s;
  logic             mode_chg_s;
  mode_e            mode_s;

  logic             hit_q,        hit_d;
  logic [IDX_W-1:0] hit_idx_q,    hit_idx_d;
  logic [IDX_W-1:0] step_q,       step_d;
  logic [CNT_W-1:0] hit_count_q,  hit_count_d;
  mode_e            mode_prev_q;
  logic [IDX_W-1:0] seq_last_prev_q;
`ifdef MPD_STICKY_EN
  logic             sticky_q,     sticky_d;
`endif

  assign mode_s = mode_e'(mode);

  // ---------------------------------------------------------------------------
  // Pattern slots
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NPAT; g++) begin : g_slot
    mpd_slot_cmp #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (cfg_we && (cfg_idx == IDX_W'(g))),
      .pattern_i (cfg_pattern),
      .mask_i    (cfg_mask),
      .en_i      (cfg_en),
      .data_i    (in_data),
      .match_o   (match_s[g])
    );
  end

  // Priority encoder: lowest matching slot index (scan high to low so the
  // last assignment is the lowest match).
  always_comb begin
    any_match_s = |match_s;
    low_idx_s   = '0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      low_idx_s = match_s[i] ? IDX_W'(i) : low_idx_s;
    end
  end

  // Match of the slot the sequence is currently waiting for; a step beyond
  // the implemented slots (seq_last >= NPAT) can never match.
  always_comb begin
    if (int'(step_q) < NPAT) begin
      step_match_s = match_s[step_q];
    end else begin
      step_match_s = 1'b0;
    end
  end

  // A mode or seq_last change restarts the sequence and discards that beat.
  always_comb begin
    mode_chg_s = (mode_s != mode_prev_q) || (seq_last != seq_last_prev_q);
  end

  // Hit generation and SEQ step next state.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    step_d    = step_q;
    if (mode_chg_s) begin
      step_d = '0;
    end else if (mode_s == MODE_ANY) begin
      step_d = '0;
      if (in_valid && any_match_s) begin
        hit_d     = 1'b1;
        hit_idx_d = low_idx_s;
      end else begin
        hit_d     = 1'b0;
      end
    end else if (cfg_we) begin
      // Configuration is being rewritten: restart, no progress this beat.
      step_d = '0;
    end else if (in_valid) begin
      if (step_match_s) begin
        if (step_q == seq_last) begin
          hit_d     = 1'b1;
          hit_idx_d = seq_last;
          step_d    = '0;
        end else begin
          step_d    = step_q + IDX_W'(1);
        end
      end else if (match_s[0] && (seq_last != '0)) begin
        // The breaking word may itself start a new sequence.
        step_d = IDX_W'(1);
      end else begin
        step_d = '0;
      end
    end else begin
      step_d = step_q;
    end
  end

  // Saturating hit counter; a clear coincident with a hit counts that hit.
  always_comb begin
    hit_count_d = hit_count_q;
    if (cnt_clr) begin
      hit_count_d = hit_d ? CNT_W'(1) : '0;
    end else if (hit_d && (hit_count_q != CNT_MAX)) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end else begin
      hit_count_d = hit_count_q;
    end
  end

`ifdef MPD_STICKY_EN
  // Sticky hit flag: a hit wins over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (hit_d) begin
      sticky_d = 1'b1;
    end else if (cnt_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q           <= 1'b0;
      hit_idx_q       <= '0;
      step_q          <= '0;
      hit_count_q     <= '0;
      mode_prev_q     <= MODE_ANY;
      seq_last_prev_q <= '0;
    end else begin
      hit_q           <= hit_d;
      hit_idx_q       <= hit_idx_d;
      step_q          <= step_d;
      hit_count_q     <= hit_count_d;
      mode_prev_q     <= mode_s;
      seq_last_prev_q <= seq_last;
    end
  end

`ifdef MPD_STICKY_EN
  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign hit_sticky = sticky_q;
`endif

  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign hit_count = hit_count_q;
  assign seq_step  = step_q;

endmodule

// File: tb/tb_masked_pattern_detector.sv
module tb_masked_pattern_detector;

  localparam int WIDTH = 16;
  localparam int NPAT  = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              mode;
  logic [1:0]        seq_last;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic [WIDTH-1:0]  cfg_pattern;
  logic [WIDTH-1:0]  cfg_mask;
  logic              cfg_en;
  logic              cnt_clr;
  logic              hit;
  logic [1:0]        hit_idx;
  logic [CNT_W-1:0]  hit_count;
  logic [1:0]        seq_step;
`ifdef MPD_STICKY_EN
  logic              hit_sticky;
`endif

  masked_pattern_detector #(
    .WIDTH(WIDTH),
    .NPAT (NPAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .seq_last   (seq_last),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_en     (cfg_en),
    .cnt_clr    (cnt_clr),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_count  (hit_count),
    .seq_step   (seq_step)
`ifdef MPD_STICKY_EN
    ,
    .hit_sticky (hit_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (what the outputs should show after each edge).
  logic [WIDTH-1:0] m_pat [NPAT];
  logic [WIDTH-1:0] m_msk [NPAT];
  bit               m_en  [NPAT];
  int               m_step, m_idx, m_cnt, m_prev_mode, m_prev_sl;
  bit               m_hit, m_sticky;

  int cur_mode = 0;
  int cur_sl   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPAT; i++) begin
      m_pat[i] = '0;
      m_msk[i] = '0;
      m_en[i]  = 1'b0;
    end
    m_step = 0; m_idx = 0; m_cnt = 0; m_hit = 1'b0; m_sticky = 1'b0;
    m_prev_mode = 0; m_prev_sl = 0;
  endtask

  function automatic bit slot_hits(input int i, input logic [WIDTH-1:0] d);
    if (i >= NPAT) return 1'b0;
    return m_en[i] && (((d ^ m_pat[i]) & m_msk[i]) == '0);
  endfunction

  // Apply one cycle of inputs, predict, then check after the edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit we, input int ci,
                       input logic [WIDTH-1:0] cp, input logic [WIDTH-1:0] cm,
                       input bit ce, input bit clr);
    bit e_hit;
    int e_idx, e_step;
    in_valid = v; in_data = d; mode = cur_mode[0]; seq_last = 2'(cur_sl);
    cfg_we = we; cfg_idx = 2'(ci); cfg_pattern = cp; cfg_mask = cm; cfg_en = ce;
    cnt_clr = clr;

    e_hit = 1'b0; e_idx = m_idx; e_step = m_step;
    if (cur_mode != m_prev_mode || cur_sl != m_prev_sl) begin
      e_step = 0;
    end else if (cur_mode == 0) begin
      e_step = 0;
      if (v) begin
        for (int i = NPAT - 1; i >= 0; i--)
          if (slot_hits(i, d)) begin e_hit = 1'b1; e_idx = i; end
      end
    end else if (we) begin
      e_step = 0;
    end else if (v) begin
      if (slot_hits(m_step, d)) begin
        if (m_step == cur_sl) begin e_hit = 1'b1; e_idx = cur_sl; e_step = 0; end
        else e_step = m_step + 1;
      end else begin
        e_step = (cur_sl > 0 && slot_hits(0, d)) ? 1 : 0;
      end
    end

    if (clr) m_cnt = e_hit ? 1 : 0;
    else if (e_hit && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (e_hit) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    if (we && ci < NPAT) begin m_pat[ci] = cp; m_msk[ci] = cm; m_en[ci] = ce; end
    m_hit = e_hit; m_idx = e_idx; m_step = e_step;
    m_prev_mode = cur_mode; m_prev_sl = cur_sl;

    @(posedge clk);
    #1;
    check_eq("hit",       32'(hit),       32'(m_hit));
    check_eq("hit_idx",   32'(hit_idx),   32'(m_idx));
    check_eq("hit_count", 32'(hit_count), 32'(m_cnt));
    check_eq("seq_step",  32'(seq_step),  32'(m_step));
`ifdef MPD_STICKY_EN
    check_eq("hit_sticky", 32'(hit_sticky), 32'(m_sticky));
`endif
  endtask

  task automatic beat(input logic [WIDTH-1:0] d);
    cycle(1'b1, d, 1'b0, 0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int ci, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m, input bit e);
    cycle(1'b0, '0, 1'b1, ci, p, m, e, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_hit"},   32'(hit),       32'd0);
    check_eq({tag, "_idx"},   32'(hit_idx),   32'd0);
    check_eq({tag, "_count"}, 32'(hit_count), 32'd0);
    check_eq({tag, "_step"},  32'(seq_step),  32'd0);
`ifdef MPD_STICKY_EN
    check_eq({tag, "_sticky"}, 32'(hit_sticky), 32'd0);
`endif
  endtask

  localparam logic [WIDTH-1:0] PA = 16'hA0A0;
  localparam logic [WIDTH-1:0] PB = 16'hB1B1;
  localparam logic [WIDTH-1:0] PC = 16'hC2C2;

  initial begin
    logic [WIDTH-1:0] d, cp, cm;
    int k, ci;
    bit v, we, ce, clr;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; seq_last = 2'd0;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_pattern = '0; cfg_mask = '0; cfg_en = 1'b0;
    cnt_clr = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ANY mode, masked low bits
    cfg(0, 16'h4628, 16'hFFF8, 1'b1);
    beat(16'h462F);
    check_eq("any_hit", 32'(hit), 32'd1);
    check_eq("any_idx", 32'(hit_idx), 32'd0);
    beat(16'h4638);
    check_eq("any_miss", 32'(hit), 32'd0);

    // Priority among all-zero-mask slots
    cfg(0, 16'h4628, 16'hFFF8, 1'b0);
    cfg(1, 16'h0000, 16'h0000, 1'b1);
    cfg(3, 16'h1234, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(16'($urandom));
      check_eq("prio_idx", 32'(hit_idx), 32'd1);
    end
    idle();
    check_eq("prio_novalid", 32'(hit), 32'd0);

    // Counter clear alone, and clear with a hit
    cycle(1'b1, 16'h5555, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    check_eq("clr_with_hit", 32'(hit_count), 32'd1);
    cycle(1'b0, '0, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    check_eq("clr_alone", 32'(hit_count), 32'd0);

    // SEQ mode, seq_last = 2
    cur_mode = 1; cur_sl = 2;
    idle();
    cfg(0, PA, 16'hFFFF, 1'b1);
    cfg(1, PB, 16'hFFFF, 1'b1);
    cfg(2, PC, 16'hFFFF, 1'b1);
    cfg(3, 16'h0000, 16'h0000, 1'b0);
    beat(PA); check_eq("seq_s1", 32'(seq_step), 32'd1);
    beat(PB); check_eq("seq_s2", 32'(seq_step), 32'd2);
    idle();
    beat(PC);
    check_eq("seq_hit", 32'(hit), 32'd1);
    check_eq("seq_hit_idx", 32'(hit_idx), 32'd2);
    beat(PA); beat(PB); beat(PA);
    check_eq("seq_restart", 32'(seq_step), 32'd1);
    beat(PB); beat(PC);
    check_eq("seq_hit2", 32'(hit), 32'd1);
    beat(PA); beat(PC);
    check_eq("seq_break", 32'(seq_step), 32'd0);

    // Config write mid-sequence
    beat(PA); beat(PB);
    cfg(2, PC, 16'hFFFF, 1'b1);
    check_eq("cfg_restart", 32'(seq_step), 32'd0);
    beat(PC);
    check_eq("cfg_nohit", 32'(hit), 32'd0);

    // Saturation then asynchronous reset mid-sequence
    for (int i = 0; i < 4; i++) begin beat(PA); beat(PB); beat(PC); end
    check_eq("sat_count", 32'(hit_count), 32'd3);
    beat(PA); beat(PB);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    beat(PA);
    check_eq("rst_slots_off", 32'(seq_step), 32'd0);
    cur_mode = 0; cur_sl = 0;
    idle();
    beat(PA);
    check_eq("rst_any_nohit", 32'(hit), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(31, 0) == 0) cur_mode = $urandom_range(1, 0);
      if ($urandom_range(31, 0) == 0) cur_sl = $urandom_range(3, 0);
      v   = ($urandom_range(3, 0) != 0);
      we  = ($urandom_range(15, 0) == 0);
      ci  = $urandom_range(3, 0);
      ce  = ($urandom_range(3, 0) != 0);
      clr = ($urandom_range(9, 0) == 0);
      cp  = 16'($urandom);
      case ($urandom_range(3, 0))
        0:       cm = 16'hFFFF;
        1:       cm = 16'h0000;
        2:       cm = 16'($urandom);
        default: cm = 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
      k = ($urandom_range(1, 0) == 1) ? (m_step % NPAT) : $urandom_range(NPAT - 1, 0);
      if ($urandom_range(3, 0) == 0) d = 16'($urandom);
      else d = m_pat[k] ^ (16'($urandom) & ~m_msk[k]);
      cycle(v, d, we, ci, cp, cm, ce, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
